// File: rtl/nubus_master.sv
// NuBus initiator: arbitrates for the bus, issues one word transfer per local
// request, waits for ACK (with timeout) and retries on "try again later".
module nubus_master #(
  parameter int ARB_SETTLE = 2,
  parameter int TIMEOUT    = 255,
  parameter int RETRY_MAX  = 3
) (
  input  logic        nub_clkn,
  input  logic        nub_resetn,
  input  logic [3:0]  nub_id,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic        nub_tm1n,
  input  logic        nub_tm0n,
  input  logic [3:0]  nub_arbn,
  input  logic [31:0] nub_ad,
  output logic        nub_startn_o,
  output logic        nub_tm1n_o,
  output logic        nub_tm0n_o,
  output logic        nub_ctl_oe,
  output logic        nub_rqstn_o,
  output logic [3:0]  nub_arbn_o,
  output logic        nub_arb_oe,
  output logic [31:0] nub_ad_o,
  output logic        nub_ad_oe,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [1:0]  mem_status,
  output logic        mstdn_o,
  output logic        busy_o
);

  localparam int ACW = (ARB_SETTLE < 2) ? 1 : $clog2(ARB_SETTLE);
  localparam int RW  = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ARB, S_WAIT_IDLE, S_START, S_DATA, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [29:0]     addr_reg, addr_next;
  logic [31:0]     wdata_reg, wdata_next;
  logic            write_reg, write_next;
  logic [31:0]     rdata_reg, rdata_next;
  logic [1:0]      status_reg, status_next;
  logic [RW-1:0]   retry_reg, retry_next;
  logic [7:0]      to_cnt_reg, to_cnt_next;
  logic [ACW-1:0]  arb_cnt_reg, arb_cnt_next;
  logic            bus_busy_reg, bus_busy_next;
  logic [3:0]      arb_match;
  logic            arb_win;
  logic            unused_ok;

  assign unused_ok = ^mem_addr[1:0];

  // Arbitration is won when every ARB line carries our own (inverted) ID.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_arb
      assign nub_arbn_o[gi] = ~nub_id[gi];
      assign arb_match[gi]  = (nub_arbn[gi] == ~nub_id[gi]);
    end
  endgenerate
  assign arb_win = &arb_match;

  assign mem_rdata  = rdata_reg;
  assign mem_status = status_reg;
  assign busy_o     = (state_reg != S_IDLE);

  // Our own START is not counted as another master's bus tenure.
  always_comb begin
    bus_busy_next = bus_busy_reg;
    if (!nub_ackn)
      bus_busy_next = 1'b0;
    else if (!nub_startn && state_reg != S_START)
      bus_busy_next = 1'b1;
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    write_next   = write_reg;
    rdata_next   = rdata_reg;
    status_next  = status_reg;
    retry_next   = retry_reg;
    to_cnt_next  = to_cnt_reg;
    arb_cnt_next = arb_cnt_reg;
    nub_startn_o = 1'b1;
    nub_tm1n_o   = 1'b1;
    nub_tm0n_o   = 1'b1;
    nub_ctl_oe   = 1'b0;
    nub_rqstn_o  = 1'b1;
    nub_arb_oe   = 1'b0;
    nub_ad_o     = 32'h0;
    nub_ad_oe    = 1'b0;
    mem_ready    = 1'b0;
    mstdn_o      = 1'b1;
    case (state_reg)
      S_IDLE: begin
        if (mem_valid) begin
          addr_next  = mem_addr[31:2];
          wdata_next = mem_wdata;
          write_next = mem_write;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        nub_rqstn_o = 1'b0;
        if (nub_startn && !bus_busy_reg) begin
          arb_cnt_next = '0;
          state_next   = S_ARB;
        end
      end
      S_ARB: begin
        nub_rqstn_o = 1'b0;
        nub_arb_oe  = 1'b1;
        if (arb_cnt_reg == ACW'(ARB_SETTLE - 1))
          state_next = arb_win ? S_WAIT_IDLE : S_REQ;
        else
          arb_cnt_next = arb_cnt_reg + 1'b1;
      end
      S_WAIT_IDLE: begin
        nub_rqstn_o = 1'b0;
        nub_arb_oe  = 1'b1;
        if (!bus_busy_reg && nub_startn)
          state_next = S_START;
      end
      S_START: begin
        nub_ctl_oe   = 1'b1;
        nub_startn_o = 1'b0;
        nub_ad_oe    = 1'b1;
        nub_ad_o     = {addr_reg, 2'b00};
        nub_tm1n_o   = ~write_reg;
        nub_tm0n_o   = 1'b0;
        to_cnt_next  = 8'd0;
        state_next   = S_DATA;
      end
      S_DATA: begin
        nub_ad_oe = write_reg;
        nub_ad_o  = wdata_reg;
        if (!nub_ackn) begin
          status_next = {nub_tm1n, nub_tm0n};
          if (!write_reg)
            rdata_next = nub_ad;
          state_next = S_DONE;
        end else if (to_cnt_reg == 8'(TIMEOUT - 2)) begin
          // DONE then falls exactly TIMEOUT cycles after START.
          status_next = 2'b01;
          state_next  = S_DONE;
        end else begin
          to_cnt_next = to_cnt_reg + 8'd1;
        end
      end
      S_DONE: begin
        if (status_reg == 2'b00 && retry_reg < RW'(RETRY_MAX)) begin
          retry_next = retry_reg + 1'b1;
          state_next = S_REQ;
        end else begin
          mem_ready  = 1'b1;
          mstdn_o    = 1'b0;
          retry_next = '0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge nub_clkn) begin
    if (!nub_resetn) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      write_reg    <= 1'b0;
      rdata_reg    <= '0;
      status_reg   <= 2'b00;
      retry_reg    <= '0;
      to_cnt_reg   <= 8'd0;
      arb_cnt_reg  <= '0;
      bus_busy_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      write_reg    <= write_next;
      rdata_reg    <= rdata_next;
      status_reg   <= status_next;
      retry_reg    <= retry_next;
      to_cnt_reg   <= to_cnt_next;
      arb_cnt_reg  <= arb_cnt_next;
      bus_busy_reg <= bus_busy_next;
    end
  end

endmodule

// File: tb/tb_nubus_master.sv
// Directed bench for nubus_master: a small bus/slave model drives responses and a
// scoreboard queue holds the status/data each local request should complete with.
module tb_nubus_master;

  localparam int TIMEOUT = 255;

  logic        nub_clkn = 1'b0;
  logic        nub_resetn;
  logic [3:0]  nub_id;
  logic        nub_startn, nub_ackn, nub_tm1n, nub_tm0n;
  logic [3:0]  nub_arbn, other_arbn;
  logic [31:0] nub_ad;
  logic        nub_startn_o, nub_tm1n_o, nub_tm0n_o, nub_ctl_oe, nub_rqstn_o;
  logic [3:0]  nub_arbn_o;
  logic        nub_arb_oe;
  logic [31:0] nub_ad_o;
  logic        nub_ad_oe;
  logic        mem_valid, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_status;
  logic        mstdn_o, busy_o;

  typedef struct {
    bit          check_rdata;
    logic [1:0]  status;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 nub_clkn = ~nub_clkn;

  // Open-collector ARB lines: low wherever any master pulls low.
  assign nub_arbn = (nub_arb_oe ? nub_arbn_o : 4'hF) & other_arbn;

  nubus_master #(.ARB_SETTLE(2), .TIMEOUT(TIMEOUT), .RETRY_MAX(3)) dut (
    .nub_clkn(nub_clkn), .nub_resetn(nub_resetn), .nub_id(nub_id),
    .nub_startn(nub_startn), .nub_ackn(nub_ackn), .nub_tm1n(nub_tm1n),
    .nub_tm0n(nub_tm0n), .nub_arbn(nub_arbn), .nub_ad(nub_ad),
    .nub_startn_o(nub_startn_o), .nub_tm1n_o(nub_tm1n_o), .nub_tm0n_o(nub_tm0n_o),
    .nub_ctl_oe(nub_ctl_oe), .nub_rqstn_o(nub_rqstn_o), .nub_arbn_o(nub_arbn_o),
    .nub_arb_oe(nub_arb_oe), .nub_ad_o(nub_ad_o), .nub_ad_oe(nub_ad_oe),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_status(mem_status), .mstdn_o(mstdn_o), .busy_o(busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input bit chk_rd, input logic [1:0] st, input logic [31:0] rd,
                       input bit push);
    exp_t e;
    e.check_rdata = chk_rd;
    e.status      = st;
    e.rdata       = rd;
    if (push) exp_q.push_back(e);
    mem_valid = 1'b1;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wd;
  endtask

  task automatic wait_start(input int budget, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge nub_clkn);
      if (nub_ctl_oe && !nub_startn_o) found = 1'b1;
    end
    chk($sformatf("%s_start_seen", tag), 64'(found), 64'd1);
  endtask

  task automatic wait_ready(input int budget, input string tag, output int cycles);
    bit   found = 1'b0;
    exp_t e;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge nub_clkn);
      cycles++;
      if (mem_ready) found = 1'b1;
    end
    chk($sformatf("%s_ready_seen", tag), 64'(found), 64'd1);
    if (found) begin
      chk($sformatf("%s_mstdn", tag), 64'(mstdn_o), 64'd0);
      chk($sformatf("%s_sb_nonempty", tag), 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk($sformatf("%s_status", tag), 64'(mem_status), 64'(e.status));
        if (e.check_rdata)
          chk($sformatf("%s_rdata", tag), 64'(mem_rdata), 64'(e.rdata));
      end
      $display("TXN %s status=%b rdata=%h cycles=%0d", tag, mem_status, mem_rdata, cycles);
    end
    mem_valid = 1'b0;
    nub_ackn  = 1'b1;
    nub_tm1n  = 1'b1;
    nub_tm0n  = 1'b1;
    nub_ad    = 32'h0;
    @(negedge nub_clkn);
    chk($sformatf("%s_single_pulse", tag), 64'(mem_ready), 64'd0);
    chk($sformatf("%s_idle_after", tag), 64'(busy_o), 64'd0);
  endtask

  initial begin
    int cyc;
    int viol;
    nub_resetn = 1'b0;
    nub_id     = 4'd3;
    nub_startn = 1'b1;
    nub_ackn   = 1'b1;
    nub_tm1n   = 1'b1;
    nub_tm0n   = 1'b1;
    other_arbn = 4'hF;
    nub_ad     = 32'h0;
    mem_valid  = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    repeat (3) @(negedge nub_clkn);
    chk("rst_ctl_oe", 64'(nub_ctl_oe), 64'd0);
    chk("rst_arb_oe", 64'(nub_arb_oe), 64'd0);
    chk("rst_ad_oe", 64'(nub_ad_oe), 64'd0);
    chk("rst_rqstn", 64'(nub_rqstn_o), 64'd1);
    chk("rst_startn", 64'(nub_startn_o), 64'd1);
    chk("rst_ready", 64'(mem_ready), 64'd0);
    chk("rst_mstdn", 64'(mstdn_o), 64'd1);
    chk("rst_rdata", 64'(mem_rdata), 64'd0);
    chk("rst_status", 64'(mem_status), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    nub_resetn = 1'b1;
    @(negedge nub_clkn);

    // Write: address phase, two data cycles, ACK complete.
    issue(1'b1, 32'hF300_0004, 32'h1234_5678, 1'b0, 2'b11, 32'h0, 1'b1);
    wait_start(40, "wr");
    chk("wr_start_ad", 64'(nub_ad_o), 64'hF300_0004);
    chk("wr_start_tm1n", 64'(nub_tm1n_o), 64'd0);
    chk("wr_start_tm0n", 64'(nub_tm0n_o), 64'd0);
    chk("wr_start_rqstn", 64'(nub_rqstn_o), 64'd1);
    chk("wr_start_arb_oe", 64'(nub_arb_oe), 64'd0);
    @(negedge nub_clkn);
    chk("wr_data1_ad", 64'(nub_ad_o), 64'h1234_5678);
    chk("wr_data1_oe", 64'(nub_ad_oe), 64'd1);
    chk("wr_data1_ctl_oe", 64'(nub_ctl_oe), 64'd0);
    @(negedge nub_clkn);
    chk("wr_data2_ad", 64'(nub_ad_o), 64'h1234_5678);
    nub_ackn = 1'b0;
    nub_tm1n = 1'b1;
    nub_tm0n = 1'b1;
    wait_ready(10, "wr", cyc);

    // Read returning data.
    issue(1'b0, 32'hF300_0000, 32'h0, 1'b1, 2'b11, 32'hCAFE_BABE, 1'b1);
    wait_start(40, "rd");
    chk("rd_start_ad", 64'(nub_ad_o), 64'hF300_0000);
    chk("rd_start_tm1n", 64'(nub_tm1n_o), 64'd1);
    @(negedge nub_clkn);
    chk("rd_data_ad_oe", 64'(nub_ad_oe), 64'd0);
    nub_ackn = 1'b0;
    nub_ad   = 32'hCAFE_BABE;
    wait_ready(10, "rd", cyc);

    // Lose to id 5, watch its START/ACK, then win.
    other_arbn = ~4'd5;
    issue(1'b1, 32'hA000_0008, 32'h55AA_55AA, 1'b0, 2'b11, 32'h0, 1'b1);
    viol = 0;
    repeat (12) begin
      @(negedge nub_clkn);
      if (nub_rqstn_o !== 1'b0 || nub_ctl_oe !== 1'b0) viol++;
    end
    other_arbn = 4'hF;
    nub_startn = 1'b0;
    @(negedge nub_clkn);
    if (nub_rqstn_o !== 1'b0 || nub_ctl_oe !== 1'b0) viol++;
    nub_startn = 1'b1;
    repeat (4) begin
      @(negedge nub_clkn);
      if (nub_rqstn_o !== 1'b0 || nub_ctl_oe !== 1'b0) viol++;
    end
    nub_ackn = 1'b0;
    @(negedge nub_clkn);
    if (nub_rqstn_o !== 1'b0 || nub_ctl_oe !== 1'b0) viol++;
    nub_ackn = 1'b1;
    chk("lose_hold_violations", 64'(viol), 64'd0);
    wait_start(40, "lose");
    @(negedge nub_clkn);
    nub_ackn = 1'b0;
    wait_ready(10, "lose", cyc);

    // Foreign START while in REQ; read ends with error status.
    issue(1'b0, 32'h0000_0100, 32'h0, 1'b1, 2'b10, 32'h0BAD_F00D, 1'b1);
    @(negedge nub_clkn);
    nub_startn = 1'b0;
    @(negedge nub_clkn);
    nub_startn = 1'b1;
    viol = 0;
    if (nub_arb_oe !== 1'b0) viol++;
    repeat (3) begin
      @(negedge nub_clkn);
      if (nub_arb_oe !== 1'b0) viol++;
    end
    chk("req_hold_violations", 64'(viol), 64'd0);
    nub_ackn = 1'b0;
    @(negedge nub_clkn);
    chk("req_ack_edge_arb_oe", 64'(nub_arb_oe), 64'd0);
    nub_ackn = 1'b1;
    @(negedge nub_clkn);
    chk("req_after_ack_arb_oe", 64'(nub_arb_oe), 64'd1);
    wait_start(40, "req");
    @(negedge nub_clkn);
    nub_ackn = 1'b0;
    nub_tm1n = 1'b1;
    nub_tm0n = 1'b0;
    nub_ad   = 32'h0BAD_F00D;
    wait_ready(10, "req", cyc);

    // Try-again-later on four attempts: three retries, then give up with 00.
    issue(1'b0, 32'h0000_0200, 32'h0, 1'b1, 2'b00, 32'h1111_0003, 1'b1);
    for (int a = 0; a < 4; a++) begin
      wait_start(40, $sformatf("retry%0d", a));
      @(negedge nub_clkn);
      nub_ackn = 1'b0;
      nub_tm1n = 1'b0;
      nub_tm0n = 1'b0;
      nub_ad   = 32'h1111_0000 + 32'(a);
      if (a < 3) begin
        @(negedge nub_clkn);
        chk($sformatf("retry%0d_no_ready", a), 64'(mem_ready), 64'd0);
        chk($sformatf("retry%0d_busy", a), 64'(busy_o), 64'd1);
        nub_ackn = 1'b1;
        nub_tm1n = 1'b1;
        nub_tm0n = 1'b1;
      end else begin
        wait_ready(10, "retry", cyc);
      end
    end

    // No ACK at all: bus timeout.
    issue(1'b0, 32'h0000_0300, 32'h0, 1'b0, 2'b01, 32'h0, 1'b1);
    wait_start(40, "tmo");
    wait_ready(TIMEOUT + 40, "tmo", cyc);
    chk("tmo_cycles", 64'(cyc), 64'(TIMEOUT));

    // Reset during DATA aborts with no completion.
    issue(1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 1'b0, 2'b11, 32'h0, 1'b0);
    wait_start(40, "rst");
    @(negedge nub_clkn);
    nub_resetn = 1'b0;
    mem_valid  = 1'b0;
    @(negedge nub_clkn);
    chk("midrst_ctl_oe", 64'(nub_ctl_oe), 64'd0);
    chk("midrst_arb_oe", 64'(nub_arb_oe), 64'd0);
    chk("midrst_ad_oe", 64'(nub_ad_oe), 64'd0);
    chk("midrst_rqstn", 64'(nub_rqstn_o), 64'd1);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_ready", 64'(mem_ready), 64'd0);
    nub_resetn = 1'b1;
    viol = 0;
    repeat (6) begin
      @(negedge nub_clkn);
      if (mem_ready !== 1'b0 || busy_o !== 1'b0) viol++;
    end
    chk("midrst_no_ready", 64'(viol), 64'd0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nubus_master.md
Name: nubus_master

Overview:
- NuBus master (initiator) controller for the card. It is the counterpart of the card's slave state machine.
- It accepts single-word requests from the local side and arbitrates for the bus. It then drives the START/address cycle and the write data, waits for the responder's ACK, and returns the read data and transfer status.
- It sits between the local request logic and the NuBus open-collector pad drivers. Every bus output has a matching output-enable.

Parameters:
- ARB_SETTLE, 2, cycles that ARB lines are driven before the win/lose compare.
- TIMEOUT, 255, cycles to wait for ACK after START before aborting (8-bit counter).
- RETRY_MAX, 3, automatic retries on "try again later" status.

Ports:
- nub_clkn  in  1  clock; all state updates on its rising edge.
- nub_resetn  in  1  reset, synchronous, active-low.
- nub_id  in  4  slot ID, active-high.
- nub_startn  in  1  bus START, as sampled.
- nub_ackn  in  1  bus ACK, as sampled.
- nub_tm1n  in  1  bus TM1, as sampled.
- nub_tm0n  in  1  bus TM0, as sampled.
- nub_arbn  in  4  bus ARB lines, as sampled.
- nub_ad  in  32  bus AD, as sampled.
- nub_startn_o  out  1  START drive; driven only while nub_ctl_oe=1.
- nub_tm1n_o  out  1  TM1 drive.
- nub_tm0n_o  out  1  TM0 drive.
- nub_ctl_oe  out  1  enable for START/TM.
- nub_rqstn_o  out  1  RQST drive; released as 1.
- nub_arbn_o  out  4  ARB drive, equal to ~nub_id.
- nub_arb_oe  out  1  enable for ARB.
- nub_ad_o  out  32  AD drive.
- nub_ad_oe  out  1  enable for AD.
- mem_valid  in  1  local request; held until mem_ready.
- mem_write  in  1  1 = write, 0 = read.
- mem_addr  in  32  word address; bits [1:0] are ignored and driven as 00.
- mem_wdata  in  32  write data.
- mem_ready  out  1  one-cycle completion pulse.
- mem_rdata  out  32  read data; valid while mem_ready=1.
- mem_status  out  2  final status; valid while mem_ready=1.
- mstdn_o  out  1  active-low master-done pulse; same cycle as mem_ready.
- busy_o  out  1  1 whenever the state is not IDLE.

Behaviour:
Reset (nub_resetn=0 at a rising edge):
- State goes to IDLE and all oe outputs go to 0.
- nub_rqstn_o=1, nub_startn_o=1, nub_tm1n_o=1, nub_tm0n_o=1.
- mem_ready=0, mstdn_o=1, mem_rdata=0, mem_status=0, retry and timeout counters=0, bus_busy=0.
- Reset in any state aborts the transfer immediately. No mem_ready is issued for the aborted transfer.

bus_busy flag (tracks other masters' transactions):
- Set when nub_startn=0 and nub_ackn=1 are sampled together.
- Cleared when nub_ackn=0 is sampled.

State IDLE:
- When mem_valid=1, capture addr, data and write, then go to REQ.

State REQ:
- nub_rqstn_o=0.
- Wait until nub_startn=1 and bus_busy=0, then set nub_arb_oe=1 and go to ARB.

State ARB:
- Drive ARB for ARB_SETTLE cycles, then compare nub_arbn with ~nub_id.
- Equal: go to WAIT_IDLE.
- Not equal: set nub_arb_oe=0 and go to REQ; RQST stays asserted.

State WAIT_IDLE:
- Keep ARB driven.
- When bus_busy=0 and nub_startn=1, go to START.

State START (exactly 1 cycle):
- nub_ctl_oe=1 and nub_startn_o=0.
- nub_ad_oe=1 with nub_ad_o={addr[31:2],2'b00}.
- nub_tm1n_o=~write and nub_tm0n_o=0 (word transfer).
- Release RQST and ARB (nub_rqstn_o=1, nub_arb_oe=0).
- Clear the timeout counter, then go to DATA.

State DATA:
- nub_startn_o=1 and TM released (nub_ctl_oe=0).
- Write: nub_ad_oe=1, nub_ad_o=wdata until ACK.
- Read: nub_ad_oe=0.
- On nub_ackn=0:
  - Capture {nub_tm1n,nub_tm0n} as status: 11 complete, 10 error, 01 bus timeout, 00 try-again-later.
  - Capture nub_ad into rdata when the transfer is a read.
  - Go to DONE.
- Timeout counter increments each cycle without ACK. On reaching TIMEOUT, set status=01 and go to DONE.

State DONE (1 cycle):
- Release all enables.
- If status=00 and retry<RETRY_MAX: increment retry and go to REQ, with no mem_ready.
- Otherwise: mem_ready=1 and mstdn_o=0 for this cycle, clear retry, and go to IDLE.

Other rules:
- Only one request is in flight. mem_valid sampled while in DONE is not accepted until IDLE.
- Throughput: at least one cycle in IDLE between transfers.
- ACK sampled in the START cycle is ignored; it belongs to a previous transaction.

Test Plan:
- Reset mid-DATA with nub_resetn=0 for one cycle → next cycle all oe=0, nub_rqstn_o=1, busy_o=0, and no mem_ready pulse.
- Write 0x1234_5678 to 0xF300_0004 with id=3; bus returns ARB=~3 and ACK two cycles after START with TM=11 → START cycle shows AD=0xF300_0004, tm1n=0, tm0n=0; next cycles show AD=0x1234_5678; exactly one mem_ready with mem_status=11.
- Read from 0xF300_0000; slave ACKs with AD=0xCAFE_BABE and TM=11 → mem_rdata=0xCAFE_BABE while mem_ready=1, and nub_ad_oe=0 throughout DATA.
- Lose arbitration (nub_arbn=~5 with id=3), then another master's START/ACK, then win → no START from this block until that ACK is sampled; nub_rqstn_o stays 0 throughout.
- ACK with TM=00 on four consecutive attempts → three re-arbitrations, then mem_ready with mem_status=00. No ACK at all → mem_ready with status=01 exactly TIMEOUT cycles after START.
- Another master's START arrives while in REQ → block stays in REQ with nub_arb_oe=0 until nub_ackn=0 is sampled.
